// File: rtl/rdc_sequencer.sv
// Arms the Request Duration Counter, captures its offender vector on interrupt,
// drains offender indices to software over valid/ready, then holds the RDC off.
module rdc_sequencer #(
  parameter  int N_CORES       = 4,
  parameter  int CORE_EVENTS   = 2,
  parameter  int HOLDOFF_WIDTH = 8,
  parameter  int CNT_WIDTH     = 16,
  localparam int N_EV          = N_CORES * CORE_EVENTS,
  localparam int ID_W          = (N_EV > 1) ? $clog2(N_EV) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sw_enable_i,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff_cycles_i,
  input  logic                     interruption_rdc_i,
  input  logic [N_EV-1:0]          interruption_vector_rdc_i,
  output logic                     rdc_enable_o,
  output logic                     irq_o,
  output logic                     evt_valid_o,
  input  logic                     evt_ready_i,
  output logic [ID_W-1:0]          evt_id_o,
  output logic [CNT_WIDTH-1:0]     episode_cnt_o,
  output logic                     busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_DRAIN,
    S_HOLDOFF
  } state_t;

  state_t                   state_q, state_d;
  logic [N_EV-1:0]          pending_q, pending_d;
  logic [HOLDOFF_WIDTH-1:0] hold_q, hold_d;
  logic [CNT_WIDTH-1:0]     episode_d;
  logic                     rdc_enable_d, irq_d, evt_valid_d;
  logic [ID_W-1:0]          evt_id_d;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic logic [ID_W-1:0] lowest_set(input logic [N_EV-1:0] vec);
    lowest_set = '0;
    for (int i = N_EV - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = ID_W'(i);
    end
  endfunction

  // NOTE: every signal driven here gets a default first so no latch is inferred;
  // blocking assignments are correct in combinational logic, sequential state uses <=.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    hold_d    = hold_q;
    episode_d = episode_cnt_o;

    if (!sw_enable_i) begin
      state_d   = S_IDLE;
      pending_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_ARM;
        S_ARM: begin
          if (interruption_rdc_i) state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          // The RDC vector is still valid in this cycle only.
          pending_d = interruption_vector_rdc_i;
          if (episode_cnt_o != '1) episode_d = episode_cnt_o + CNT_WIDTH'(1);
          state_d = (|interruption_vector_rdc_i) ? S_DRAIN : S_HOLDOFF;
        end
        S_DRAIN: begin
          if (evt_ready_i) begin
            pending_d = pending_q & ~(N_EV'(1) << evt_id_o);
            if (pending_d == '0) state_d = S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (hold_q == '0) state_d = S_ARM;
          else              hold_d  = hold_q - HOLDOFF_WIDTH'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Hold-off length is sampled once, on the edge that enters HOLDOFF.
    if (state_d == S_HOLDOFF && state_q != S_HOLDOFF) hold_d = holdoff_cycles_i;

    rdc_enable_d = (state_d == S_ARM);
    irq_d        = (state_d == S_DRAIN);
    evt_valid_d  = (state_d == S_DRAIN);
    evt_id_d     = (state_d == S_DRAIN) ? lowest_set(pending_d) : '0;
  end

  // NOTE: reset is synchronous and clears the pending vector as well, so offenders
  // captured before a reset can never be presented afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      pending_q     <= '0;
      hold_q        <= '0;
      episode_cnt_o <= '0;
      rdc_enable_o  <= 1'b0;
      irq_o         <= 1'b0;
      evt_valid_o   <= 1'b0;
      evt_id_o      <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      hold_q        <= hold_d;
      episode_cnt_o <= episode_d;
      rdc_enable_o  <= rdc_enable_d;
      irq_o         <= irq_d;
      evt_valid_o   <= evt_valid_d;
      evt_id_o      <= evt_id_d;
    end
  end

  assign busy_o = (state_q == S_CAPTURE) || (state_q == S_DRAIN) || (state_q == S_HOLDOFF);

endmodule

// File: tb/tb_rdc_sequencer.sv
// Randomised self-checking bench for rdc_sequencer; a second instance with a
// 2-bit episode counter shares the stimulus to exercise saturation.
module tb_rdc_sequencer;

  logic       clk = 1'b0;
  logic       rst, sw_en, irq_in, ready;
  logic [7:0] hold;
  logic [7:0] vec;

  logic        rdc_en, irq, valid, busy;
  logic [2:0]  id;
  logic [15:0] cnt;
  logic        s_rdc_en, s_irq, s_valid, s_busy;
  logic [2:0]  s_id;
  logic [1:0]  s_cnt;

  int passed = 0;
  int total  = 0;
  int episodes = 0;

  always #5 clk = ~clk;

  rdc_sequencer dut (
    .clk_i(clk), .rst_i(rst), .sw_enable_i(sw_en), .holdoff_cycles_i(hold),
    .interruption_rdc_i(irq_in), .interruption_vector_rdc_i(vec),
    .rdc_enable_o(rdc_en), .irq_o(irq), .evt_valid_o(valid), .evt_ready_i(ready),
    .evt_id_o(id), .episode_cnt_o(cnt), .busy_o(busy)
  );

  rdc_sequencer #(.CNT_WIDTH(2)) dut_small (
    .clk_i(clk), .rst_i(rst), .sw_enable_i(sw_en), .holdoff_cycles_i(hold),
    .interruption_rdc_i(irq_in), .interruption_vector_rdc_i(vec),
    .rdc_enable_o(s_rdc_en), .irq_o(s_irq), .evt_valid_o(s_valid), .evt_ready_i(ready),
    .evt_id_o(s_id), .episode_cnt_o(s_cnt), .busy_o(s_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full episode from ARM back to ARM: {rdc_en,irq,valid,busy} per phase.
  task automatic run_episode(input logic [7:0] v, input int h, input int low_cycles,
                             input bit rnd_ready);
    int q[$];
    int guard;
    int exp_small;
    hold   = 8'(h);
    irq_in = 1'b1;
    vec    = v;
    tick();
    total++;
    if ({rdc_en, irq, valid, busy} !== 4'b0001) begin
      $display("FAIL capture_flags: got %b expected 0001", {rdc_en, irq, valid, busy});
    end else passed++;
    irq_in = 1'b0;
    tick();
    vec = '0;
    episodes++;
    exp_small = (episodes > 3) ? 3 : episodes;
    total++;
    if (cnt !== 16'(episodes)) begin
      $display("FAIL episode_cnt: got %0d expected %0d", cnt, episodes);
    end else passed++;
    total++;
    if (s_cnt !== 2'(exp_small)) begin
      $display("FAIL episode_cnt_sat: got %0d expected %0d", s_cnt, exp_small);
    end else passed++;

    for (int i = 0; i < 8; i++) if (v[i]) q.push_back(i);
    guard = 0;
    while (q.size() > 0 && guard < 300) begin
      total++;
      if ({rdc_en, irq, valid, busy} !== 4'b0111 || id !== 3'(q[0])) begin
        $display("FAIL drain: flags %b id %0d expected flags 0111 id %0d",
                 {rdc_en, irq, valid, busy}, id, q[0]);
      end else passed++;
      ready  = (guard < low_cycles) ? 1'b0 : (rnd_ready ? 1'($urandom % 2) : 1'b1);
      irq_in = 1'($urandom % 2);
      tick();
      if (ready) void'(q.pop_front());
      guard++;
    end
    total++;
    if (q.size() != 0) begin
      $display("FAIL drain_timeout: %0d ids left expected 0", q.size());
    end else passed++;
    ready = 1'b0;

    for (int k = 0; k <= h; k++) begin
      total++;
      if ({rdc_en, irq, valid, busy} !== 4'b0001) begin
        $display("FAIL holdoff_%0d: got %b expected 0001", k, {rdc_en, irq, valid, busy});
      end else passed++;
      irq_in = 1'($urandom % 2);
      tick();
    end
    irq_in = 1'b0;
    total++;
    if ({rdc_en, irq, valid, busy} !== 4'b1000) begin
      $display("FAIL rearm: got %b expected 1000", {rdc_en, irq, valid, busy});
    end else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; sw_en = 1'b0; irq_in = 1'b0; ready = 1'b0; hold = '0; vec = '0;
    tick();
    tick();
    episodes = 0;
    total++;
    if ({rdc_en, irq, valid, busy, id, cnt} !== '0 ||
        {s_rdc_en, s_irq, s_valid, s_busy, s_id, s_cnt} !== '0) begin
      $display("FAIL reset_values: got %h / %h expected 0", {rdc_en, irq, valid, busy, id, cnt},
               {s_rdc_en, s_irq, s_valid, s_busy, s_id, s_cnt});
    end else passed++;
    rst = 1'b0;
    tick();
    total++;
    if ({rdc_en, busy} !== 2'b00) begin
      $display("FAIL idle_hold: got %b expected 00", {rdc_en, busy});
    end else passed++;
    sw_en = 1'b1;
    tick();
    total++;
    if ({rdc_en, irq, valid, busy} !== 4'b1000 || cnt !== 16'd0) begin
      $display("FAIL arm_after_enable: got %b cnt %0d expected 1000 cnt 0",
               {rdc_en, irq, valid, busy}, cnt);
    end else passed++;
  endtask

  task automatic test_basic();
    run_episode(8'b0010_0100, 3, 0, 1'b0);
  endtask

  task automatic test_ready_stall();
    run_episode(8'b0010_0100, 2, 5, 1'b0);
  endtask

  task automatic test_enable_drop();
    irq_in = 1'b1; vec = 8'b1001_0010;
    tick();
    irq_in = 1'b0;
    tick();
    vec = '0;
    episodes++;
    total++;
    if ({valid, irq} !== 2'b11 || id !== 3'd1) begin
      $display("FAIL drop_pre: valid/irq %b id %0d expected 11 id 1", {valid, irq}, id);
    end else passed++;
    sw_en = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({rdc_en, irq, valid, busy} !== 4'b0000) begin
        $display("FAIL drop_idle_%0d: got %b expected 0000", k, {rdc_en, irq, valid, busy});
      end else passed++;
      tick();
    end
    sw_en = 1'b1;
    tick();
    total++;
    if ({rdc_en, irq, valid, busy} !== 4'b1000) begin
      $display("FAIL drop_rearm: got %b expected 1000", {rdc_en, irq, valid, busy});
    end else passed++;

    // Last handshake coinciding with the enable drop still lands in IDLE.
    irq_in = 1'b1; vec = 8'b0100_0000;
    tick();
    irq_in = 1'b0;
    tick();
    vec = '0;
    episodes++;
    ready = 1'b1; sw_en = 1'b0;
    tick();
    ready = 1'b0;
    total++;
    if ({rdc_en, irq, valid, busy} !== 4'b0000) begin
      $display("FAIL drop_last_hs: got %b expected 0000", {rdc_en, irq, valid, busy});
    end else passed++;
    sw_en = 1'b1;
    tick();
    run_episode(8'b0000_1000, 1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      for (int w = 0; w < int'($urandom % 3); w++) begin
        total++;
        if (rdc_en !== 1'b1 || busy !== 1'b0) begin
          $display("FAIL arm_wait: rdc_en %b busy %b expected 1 0", rdc_en, busy);
        end else passed++;
        tick();
      end
      run_episode(8'($urandom), int'($urandom % 6), int'($urandom % 3), 1'b1);
    end
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    episodes = 0;
    tick();
    run_episode(8'b0000_0001, 0, 0, 1'b0);
    run_episode(8'b0000_0000, 1, 0, 1'b0);
    run_episode(8'b1100_0000, 0, 0, 1'b1);
    run_episode(8'b0001_0001, 2, 0, 1'b1);
  endtask

  task automatic test_reset_holdoff();
    hold = 8'd20; irq_in = 1'b1; vec = '0;
    tick();
    irq_in = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({rdc_en, irq, valid, busy, id, cnt} !== '0 || s_cnt !== 2'd0) begin
        $display("FAIL reset_in_holdoff_%0d: got %h expected 0", k,
                 {rdc_en, irq, valid, busy, id, cnt});
      end else passed++;
    end
    sw_en = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({rdc_en, busy} !== 2'b00) begin
        $display("FAIL no_spurious_arm_%0d: got %b expected 00", k, {rdc_en, busy});
      end else passed++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_ready_stall();
    test_enable_drop();
    test_random();
    test_saturation();
    test_reset_holdoff();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
